ctech_lib_clk_gate_or_hyst: RTL and testbench

Parametrised, multi-channel OR-type clock gate with a per-channel idle-hysteresis controller.
Each channel's output clock runs while its domain is busy. After a programmable number of consecutive idle cycles, the output is parked high. It wakes one cycle after activity returns.
Sits at the root of gated sub-domains, replacing hand-instantiated single-bit OR gates plus ad-hoc enable logic.

---
 rtl/ctech_lib_clk_gate_pkg.sv | 18 +
 rtl/ctech_lib_clk_gate_or_cell.sv | 20 ++
 rtl/ctech_lib_clk_gate_or_hyst.sv | 103 ++++++++++
 tb/tb_ctech_lib_clk_gate_or_hyst.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/ctech_lib_clk_gate_pkg.sv
// rtl/ctech_lib_clk_gate_pkg.sv - shared types, defaults and helpers for the OR-type clock gate
package ctech_lib_clk_gate_pkg;

    typedef enum logic [1:0] {
        CG_ON    = 2'd0,
        CG_DRAIN = 2'd1,
        CG_OFF   = 2'd2
    } cg_state_t;

    localparam int CG_NUM_CH_DEF = 4;
    localparam int CG_HYST_W_DEF = 8;

    // A hysteresis of zero would never gate sensibly, so it behaves as one idle cycle.
    function automatic logic [31:0] hyst_eff(input logic [31:0] hv);
        return (hv == 32'd0) ? 32'd1 : hv;
    endfunction

endpackage

// File: rtl/ctech_lib_clk_gate_or_cell.sv
// rtl/ctech_lib_clk_gate_or_cell.sv - latch plus OR gate cell, output parked high when disabled
module ctech_lib_clk_gate_or_cell (
    input  logic clk,
    input  logic en,
    output logic clkout
);

    logic en_lat;

    // Enable is captured while clk is high, where the OR output is already 1, so
    // enable changes can never shorten or add a pulse on clkout.
    always_latch begin
        if (clk) begin
            en_lat <= en;
        end
    end

    assign clkout = clk | ~en_lat;

endmodule

// File: rtl/ctech_lib_clk_gate_or_hyst.sv
// rtl/ctech_lib_clk_gate_or_hyst.sv - multi-channel OR clock gate with per-channel idle hysteresis
module ctech_lib_clk_gate_or_hyst
    import ctech_lib_clk_gate_pkg::*;
#(
    parameter int NUM_CH = CG_NUM_CH_DEF,
    parameter int HYST_W = CG_HYST_W_DEF,
    parameter bit RST_EN = 1'b1
) (
    input  logic              clk,
    input  logic              rst_b,
    input  logic              test_en,
    input  logic [HYST_W-1:0] hyst_val,
    input  logic [NUM_CH-1:0] busy,
    input  logic [NUM_CH-1:0] force_on,
    output logic [NUM_CH-1:0] clkout,
    output logic [NUM_CH-1:0] gated_sts,
    output logic [NUM_CH-1:0] wake_pls
);

    localparam cg_state_t       RST_STATE = RST_EN ? CG_ON : CG_OFF;
    localparam logic [HYST_W-1:0] HV_ONE  = HYST_W'(1);

    logic [HYST_W-1:0] hv_eff;

    assign hv_eff = HYST_W'(hyst_eff(32'(hyst_val)));

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        cg_state_t         state_q, state_d;
        logic [HYST_W-1:0] cnt_q, cnt_d;
        logic              en_q, sts_q, wake_q, wake_d;
        logic              act;

        assign act = busy[i] | force_on[i];

        // Next-state: hysteresis is latched only on entry to DRAIN, so later
        // hyst_val changes leave an in-flight drain untouched.
        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            wake_d  = 1'b0;
            case (state_q)
                CG_ON: begin
                    if (!act) begin
                        if (hv_eff == HV_ONE) begin
                            state_d = CG_OFF;
                        end else begin
                            state_d = CG_DRAIN;
                            cnt_d   = hv_eff - HV_ONE;
                        end
                    end
                end
                CG_DRAIN: begin
                    if (act) begin
                        state_d = CG_ON;
                        cnt_d   = '0;
                    end else if (cnt_q == HV_ONE) begin
                        state_d = CG_OFF;
                    end else begin
                        cnt_d = cnt_q - HV_ONE;
                    end
                end
                CG_OFF: begin
                    if (act) begin
                        state_d = CG_ON;
                        wake_d  = 1'b1;
                    end
                end
                default: begin
                    state_d = RST_STATE;
                    cnt_d   = '0;
                end
            endcase
        end

        // State register; enable and status are registered from next-state so
        // gating takes effect at the same edge that decides it.
        always_ff @(posedge clk or negedge rst_b) begin
            if (!rst_b) begin
                state_q <= RST_STATE;
                cnt_q   <= '0;
                en_q    <= RST_EN;
                sts_q   <= ~RST_EN;
                wake_q  <= 1'b0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                en_q    <= (state_d != CG_OFF);
                sts_q   <= (state_d == CG_OFF);
                wake_q  <= wake_d;
            end
        end

        ctech_lib_clk_gate_or_cell u_cell (
            .clk    (clk),
            .en     (en_q | test_en),
            .clkout (clkout[i])
        );

        assign gated_sts[i] = sts_q;
        assign wake_pls[i]  = wake_q;
    end

endmodule

// File: tb/tb_ctech_lib_clk_gate_or_hyst.sv
// tb/tb_ctech_lib_clk_gate_or_hyst.sv - self-checking bench for the OR clock gate with hysteresis
module tb_ctech_lib_clk_gate_or_hyst;

    logic       clk;
    logic       rst_b;
    logic       test_en;
    logic [7:0] hyst_val;
    logic [3:0] busy;
    logic [3:0] force_on;
    logic [3:0] clkout;
    logic [3:0] gated_sts;
    logic [3:0] wake_pls;

    int vectors = 0;
    int errs    = 0;

    ctech_lib_clk_gate_or_hyst #(
        .NUM_CH (4),
        .HYST_W (8),
        .RST_EN (1'b1)
    ) dut (
        .clk       (clk),
        .rst_b     (rst_b),
        .test_en   (test_en),
        .hyst_val  (hyst_val),
        .busy      (busy),
        .force_on  (force_on),
        .clkout    (clkout),
        .gated_sts (gated_sts),
        .wake_pls  (wake_pls)
    );

    time t_clk = 0;
    initial clk = 1'b0;
    always begin
        #5;
        t_clk = $time;
        clk   = ~clk;
    end

    // Every clkout transition must coincide with a clk edge and follow clk's new level.
    int         runt_cnt = 0;
    int         edge_cnt = 0;
    bit         mon_en   = 1'b0;
    logic [3:0] co_prev  = 4'hF;
    always @(clkout) begin
        for (int i = 0; i < 4; i++) begin
            if (mon_en && (clkout[i] !== co_prev[i])) begin
                edge_cnt++;
                if (($time != t_clk) || (clkout[i] !== clk)) runt_cnt++;
            end
        end
        co_prev = clkout;
    end

    // Reference model: count consecutive idle samples, the target being the clamped
    // hysteresis seen on the first idle sample of the run.
    int         run[4];
    int         tgt[4];
    bit         off[4];
    logic [3:0] wake_exp;

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            run[i] = 0;
            tgt[i] = 1;
            off[i] = 1'b0;
        end
        wake_exp = 4'h0;
    endtask

    task automatic model_edge();
        for (int i = 0; i < 4; i++) begin
            if (busy[i] || force_on[i]) begin
                wake_exp[i] = off[i];
                off[i]      = 1'b0;
                run[i]      = 0;
            end else begin
                wake_exp[i] = 1'b0;
                if (run[i] == 0) tgt[i] = (hyst_val == 8'd0) ? 1 : int'(hyst_val);
                if (run[i] < tgt[i]) run[i]++;
                if (run[i] >= tgt[i]) off[i] = 1'b1;
            end
        end
    endtask

    function automatic logic [3:0] sts_exp();
        logic [3:0] s;
        for (int i = 0; i < 4; i++) s[i] = off[i];
        return s;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic [3:0] b, input logic [3:0] f, input logic [7:0] hv, input logic te);
        busy     = b;
        force_on = f;
        hyst_val = hv;
        test_en  = te;
        @(posedge clk);
        model_edge();
        #2;
        chk("clk_high", clkout, 4'hF);
        @(negedge clk);
        #1;
        chk("gated_sts", gated_sts, sts_exp());
        chk("wake_pls", wake_pls, wake_exp);
        chk("clk_low", clkout, sts_exp() & ~{4{te}});
    endtask

    initial begin
        rst_b    = 1'b1;
        busy     = 4'h0;
        force_on = 4'h0;
        hyst_val = 8'd4;
        test_en  = 1'b0;
        model_reset();
        #1 rst_b = 1'b0;
        @(posedge clk);
        @(negedge clk);
        #1;
        chk("rst_sts", gated_sts, 4'h0);
        chk("rst_wake", wake_pls, 4'h0);
        chk("rst_clk_low", clkout, 4'h0);
        mon_en = 1'b1;
        rst_b  = 1'b1;

        // Idle from reset with hysteresis 4: gates at the fourth edge.
        repeat (3) step(4'h0, 4'h0, 8'd4, 1'b0);
        chk("tp1_pre_gate", gated_sts, 4'h0);
        step(4'h0, 4'h0, 8'd4, 1'b0);
        chk("tp1_gate", gated_sts, 4'hF);
        chk("tp1_no_wake", wake_pls, 4'h0);
        step(4'h0, 4'h0, 8'd4, 1'b0);

        // One-cycle busy on channel 0 wakes it, then re-gates after 4 idle cycles.
        step(4'h1, 4'h0, 8'd4, 1'b0);
        chk("tp2_wake", wake_pls, 4'h1);
        chk("tp2_clk_low", clkout, 4'hE);
        repeat (3) step(4'h0, 4'h0, 8'd4, 1'b0);
        chk("tp2_pre_regate", gated_sts, 4'hE);
        step(4'h0, 4'h0, 8'd4, 1'b0);
        chk("tp2_regate", gated_sts, 4'hF);

        // Hysteresis 0 and 1 both gate after a single idle cycle.
        step(4'hF, 4'h0, 8'd0, 1'b0);
        step(4'h0, 4'h0, 8'd0, 1'b0);
        chk("tp3_hv0", gated_sts, 4'hF);
        step(4'hF, 4'h0, 8'd1, 1'b0);
        step(4'h0, 4'h0, 8'd1, 1'b0);
        chk("tp3_hv1", gated_sts, 4'hF);

        // Hysteresis changed 8 -> 2 during drain: the drain still takes 8 cycles.
        step(4'hF, 4'h0, 8'd8, 1'b0);
        step(4'h0, 4'h0, 8'd8, 1'b0);
        repeat (6) step(4'h0, 4'h0, 8'd2, 1'b0);
        chk("tp3_drain7", gated_sts, 4'h0);
        step(4'h0, 4'h0, 8'd2, 1'b0);
        chk("tp3_drain8", gated_sts, 4'hF);

        // Three idle cycles then activity: stays on; the next full run gates.
        step(4'hF, 4'h0, 8'd4, 1'b0);
        repeat (3) step(4'h0, 4'h0, 8'd4, 1'b0);
        step(4'hF, 4'h0, 8'd4, 1'b0);
        chk("tp4_no_gate", gated_sts, 4'h0);
        repeat (4) step(4'h0, 4'h0, 8'd4, 1'b0);
        chk("tp4_gate", gated_sts, 4'hF);

        // Test override runs gated clocks without disturbing status.
        step(4'h0, 4'h0, 8'd4, 1'b1);
        chk("tp5_te_clk_low", clkout, 4'h0);
        chk("tp5_te_sts", gated_sts, 4'hF);
        step(4'h0, 4'h0, 8'd4, 1'b1);
        step(4'h0, 4'h0, 8'd4, 1'b0);
        chk("tp5_te_off", clkout, 4'hF);

        // Software force keeps channel 1 running under random busy.
        for (int n = 0; n < 40; n++) begin
            step(4'($urandom_range(0, 15)) & 4'b1101, 4'b0010, 8'($urandom_range(0, 3)), 1'b0);
        end
        chk("tp5_force_on", gated_sts[1], 1'b0);

        // Random traffic, sparse enough that channels drain and gate regularly.
        for (int n = 0; n < 300; n++) begin
            logic [3:0] b, f;
            for (int i = 0; i < 4; i++) begin
                b[i] = ($urandom_range(0, 3) == 0);
                f[i] = ($urandom_range(0, 15) == 0);
            end
            step(b, f, 8'($urandom_range(0, 5)), ($urandom_range(0, 15) == 0));
        end

        // Asynchronous reset mid low phase with channels 0/1 draining, 2/3 off.
        step(4'hF, 4'h0, 8'd1, 1'b0);
        step(4'h3, 4'h0, 8'd1, 1'b0);
        step(4'h0, 4'h0, 8'd3, 1'b0);
        chk("tp6_pre_clk_low", clkout, 4'hC);
        #1 rst_b = 1'b0;
        #1;
        chk("tp6_rst_sts", gated_sts, 4'h0);
        chk("tp6_rst_wake", wake_pls, 4'h0);
        chk("tp6_rst_clk_hold", clkout, 4'hC);
        @(posedge clk);
        #2;
        chk("tp6_rst_clk_high", clkout, 4'hF);
        @(negedge clk);
        #1;
        chk("tp6_rst_clk_low", clkout, 4'h0);
        rst_b = 1'b1;
        model_reset();
        step(4'h0, 4'h0, 8'd2, 1'b0);
        step(4'h0, 4'h0, 8'd2, 1'b0);
        chk("tp6_post_gate", gated_sts, 4'hF);

        chk("edges_seen", 32'(edge_cnt > 200), 32'd1);
        chk("no_runt", runt_cnt, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
